// File: rtl/cmul_job_arbiter_pkg.sv
// Shared types and constants for the two-requester complex-multiply job arbiter.
package cmul_job_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      COLLECT = 2'd2
   } state_t;

   localparam int N_WORDS = 4;
   localparam int N_RES   = 3;

   localparam logic MODE_CMUL   = 1'b0;
   localparam logic MODE_MINMAX = 1'b1;

endpackage

// File: rtl/cmul_job_arbiter_if.sv
// Requester, engine and result signals of the job arbiter; master is the arbiter side.
interface cmul_job_arbiter_if #(
   parameter int DW = 16,
   parameter int OW = 36
);
   logic              req0_valid;
   logic              req0_mode;
   logic [4*DW-1:0]   req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic              req1_mode;
   logic [4*DW-1:0]   req1_data;
   logic              req1_ready;
   logic              eng_in_valid;
   logic [DW-1:0]     eng_in;
   logic              eng_in_mode;
   logic              eng_out_valid;
   logic [OW-1:0]     eng_out;
   logic              res_valid;
   logic              res_id;
   logic [1:0]        res_idx;
   logic [OW-1:0]     res_data;
   logic              busy;
   logic              err;

   modport master (
      input  req0_valid, req0_mode, req0_data,
      input  req1_valid, req1_mode, req1_data,
      input  eng_out_valid, eng_out,
      output req0_ready, req1_ready,
      output eng_in_valid, eng_in, eng_in_mode,
      output res_valid, res_id, res_idx, res_data,
      output busy, err
   );

   modport slave (
      output req0_valid, req0_mode, req0_data,
      output req1_valid, req1_mode, req1_data,
      output eng_out_valid, eng_out,
      input  req0_ready, req1_ready,
      input  eng_in_valid, eng_in, eng_in_mode,
      input  res_valid, res_id, res_idx, res_data,
      input  busy, err
   );
endinterface

// File: rtl/cmul_job_arbiter_rr_pick2.sv
// Two-way round-robin selector: on contention the requester that was not granted last wins.
module rr_pick2 (
   input  logic       i_valid0,
   input  logic       i_valid1,
   input  logic       i_last,
   output logic [1:0] o_grant
);

   // one-hot grant; i_last = 1 means requester 1 was served most recently
   always_comb begin
      o_grant = 2'b00;
      if (i_valid0 && (!i_valid1 || i_last)) begin
         o_grant = 2'b01;
      end else if (i_valid1) begin
         o_grant = 2'b10;
      end else begin
         o_grant = 2'b00;
      end
   end

endmodule

// File: rtl/cmul_job_arbiter.sv
// Shares one engine between two requesters: grants a whole job, streams its four words,
// then forwards the three results tagged with owner and index.
module cmul_job_arbiter
   import cmul_job_arbiter_pkg::*;
#(
   parameter int DW       = 16,
   parameter int OW       = 36,
   parameter int WAIT_MAX = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   cmul_job_arbiter_if.master bus
);

   localparam int          TW        = $clog2(WAIT_MAX + 1);
   localparam logic [1:0]  LAST_WORD = 2'(N_WORDS - 1);
   localparam logic [1:0]  LAST_RES  = 2'(N_RES - 1);

   state_t                 r_state,  w_state_nxt;
   logic [1:0]             r_wc,     w_wc_nxt;
   logic [1:0]             r_rc,     w_rc_nxt;
   logic [TW-1:0]          r_timer,  w_timer_nxt;
   logic                   r_mode,   w_mode_nxt;
   logic [N_WORDS*DW-1:0]  r_data,   w_data_nxt;
   logic                   r_owner,  w_owner_nxt;
   logic                   r_last_grant, w_last_grant_nxt;
   logic                   r_eng_in_valid, w_eng_in_valid_nxt;
   logic [DW-1:0]          r_eng_in,       w_eng_in_nxt;
   logic                   r_eng_in_mode,  w_eng_in_mode_nxt;
   logic                   r_res_valid,    w_res_valid_nxt;
   logic                   r_res_id,       w_res_id_nxt;
   logic [1:0]             r_res_idx,      w_res_idx_nxt;
   logic [OW-1:0]          r_res_data,     w_res_data_nxt;
   logic                   r_err,          w_err_nxt;

   logic [1:0]             w_grant;
   logic                   w_sel_mode;
   logic [N_WORDS*DW-1:0]  w_sel_data;

   function automatic logic [DW-1:0] word_sel(input logic [N_WORDS*DW-1:0] d,
                                              input logic [1:0]            k);
      word_sel = d[DW*int'(k) +: DW];
   endfunction

   rr_pick2 u_pick (
      .i_valid0 (bus.req0_valid),
      .i_valid1 (bus.req1_valid),
      .i_last   (r_last_grant),
      .o_grant  (w_grant)
   );

   assign w_sel_mode     = w_grant[1] ? bus.req1_mode : bus.req0_mode;
   assign w_sel_data     = w_grant[1] ? bus.req1_data : bus.req0_data;

   assign bus.req0_ready   = (r_state == IDLE) & w_grant[0];
   assign bus.req1_ready   = (r_state == IDLE) & w_grant[1];
   assign bus.eng_in_valid = r_eng_in_valid;
   assign bus.eng_in       = r_eng_in;
   assign bus.eng_in_mode  = r_eng_in_mode;
   assign bus.res_valid    = r_res_valid;
   assign bus.res_id       = r_res_id;
   assign bus.res_idx      = r_res_idx;
   assign bus.res_data     = r_res_data;
   // busy also covers the cycle the final result is still on the output
   assign bus.busy         = (r_state != IDLE) | r_res_valid;
   assign bus.err          = r_err;

   // next-state and next-output logic
   always_comb begin
      w_state_nxt        = r_state;
      w_wc_nxt           = r_wc;
      w_rc_nxt           = r_rc;
      w_timer_nxt        = r_timer;
      w_mode_nxt         = r_mode;
      w_data_nxt         = r_data;
      w_owner_nxt        = r_owner;
      w_last_grant_nxt   = r_last_grant;
      w_eng_in_valid_nxt = 1'b0;
      w_eng_in_nxt       = {DW{1'b0}};
      w_eng_in_mode_nxt  = r_eng_in_mode;
      w_res_valid_nxt    = 1'b0;
      w_res_id_nxt       = r_res_id;
      w_res_idx_nxt      = r_res_idx;
      w_res_data_nxt     = r_res_data;
      w_err_nxt          = r_err;

      case (r_state)
         IDLE: begin
            if (bus.eng_out_valid) begin
               w_err_nxt = 1'b1;
            end else begin
               w_err_nxt = r_err;
            end
            if (w_grant != 2'b00) begin
               w_mode_nxt         = (w_sel_mode == MODE_MINMAX) ? MODE_MINMAX : MODE_CMUL;
               w_data_nxt         = w_sel_data;
               w_owner_nxt        = w_grant[1];
               w_last_grant_nxt   = w_grant[1];
               w_wc_nxt           = 2'd0;
               w_eng_in_valid_nxt = 1'b1;
               w_eng_in_nxt       = word_sel(w_sel_data, 2'd0);
               w_eng_in_mode_nxt  = w_sel_mode;
               w_state_nxt        = SEND;
            end else begin
               w_state_nxt        = IDLE;
            end
         end
         SEND: begin
            if (bus.eng_out_valid) begin
               w_err_nxt = 1'b1;
            end else begin
               w_err_nxt = r_err;
            end
            // r_wc is the word currently on eng_in
            if (r_wc == LAST_WORD) begin
               w_rc_nxt    = 2'd0;
               w_timer_nxt = {TW{1'b0}};
               w_state_nxt = COLLECT;
            end else begin
               w_wc_nxt           = r_wc + 2'd1;
               w_eng_in_valid_nxt = 1'b1;
               w_eng_in_nxt       = word_sel(r_data, r_wc + 2'd1);
               w_eng_in_mode_nxt  = r_mode;
            end
         end
         COLLECT: begin
            if (bus.eng_out_valid) begin
               w_res_valid_nxt = 1'b1;
               w_res_data_nxt  = bus.eng_out;
               w_res_idx_nxt   = r_rc;
               w_res_id_nxt    = r_owner;
               w_timer_nxt     = {TW{1'b0}};
               if (r_rc == LAST_RES) begin
                  w_rc_nxt    = 2'd0;
                  w_state_nxt = IDLE;
               end else begin
                  w_rc_nxt    = r_rc + 2'd1;
               end
            end else if (r_timer == TW'(WAIT_MAX)) begin
               w_err_nxt   = 1'b1;
               w_rc_nxt    = 2'd0;
               w_timer_nxt = {TW{1'b0}};
               w_state_nxt = IDLE;
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // state and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_wc           <= 2'd0;
         r_rc           <= 2'd0;
         r_timer        <= {TW{1'b0}};
         r_mode         <= MODE_CMUL;
         r_data         <= {(N_WORDS*DW){1'b0}};
         r_owner        <= 1'b0;
         r_last_grant   <= 1'b1;
         r_eng_in_valid <= 1'b0;
         r_eng_in       <= {DW{1'b0}};
         r_eng_in_mode  <= MODE_CMUL;
         r_res_valid    <= 1'b0;
         r_res_id       <= 1'b0;
         r_res_idx      <= 2'd0;
         r_res_data     <= {OW{1'b0}};
         r_err          <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_wc           <= w_wc_nxt;
         r_rc           <= w_rc_nxt;
         r_timer        <= w_timer_nxt;
         r_mode         <= w_mode_nxt;
         r_data         <= w_data_nxt;
         r_owner        <= w_owner_nxt;
         r_last_grant   <= w_last_grant_nxt;
         r_eng_in_valid <= w_eng_in_valid_nxt;
         r_eng_in       <= w_eng_in_nxt;
         r_eng_in_mode  <= w_eng_in_mode_nxt;
         r_res_valid    <= w_res_valid_nxt;
         r_res_id       <= w_res_id_nxt;
         r_res_idx      <= w_res_idx_nxt;
         r_res_data     <= w_res_data_nxt;
         r_err          <= w_err_nxt;
      end
   end

endmodule

// File: tb/tb_cmul_job_arbiter.sv
// Scoreboard bench for cmul_job_arbiter: stimulus pushes expected engine words and results,
// a negedge monitor pops and compares them whenever the DUT strobes.
module tb_cmul_job_arbiter;
   import cmul_job_arbiter_pkg::*;

   localparam int DW = 16;
   localparam int OW = 36;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   cmul_job_arbiter_if #(.DW(DW), .OW(OW)) bus ();

   cmul_job_arbiter #(.DW(DW), .OW(OW), .WAIT_MAX(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [DW-1:0] w; logic m; int c; } eng_exp_t;
   typedef struct { logic id; logic [1:0] idx; logic [OW-1:0] d; int c; } res_exp_t;

   eng_exp_t eng_q[$];
   res_exp_t res_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: every engine strobe and result strobe must match the head of its queue
   always @(negedge clk) begin
      eng_exp_t e;
      res_exp_t r;
      if (bus.eng_in_valid === 1'b1) begin
         if (eng_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL eng_unexpected: got word %0h expected no strobe (cycle %0d)", bus.eng_in, cyc);
         end else begin
            e = eng_q.pop_front();
            chk("eng_word",  64'(bus.eng_in),      64'(e.w));
            chk("eng_mode",  64'(bus.eng_in_mode), 64'(e.m));
            chk("eng_cycle", 64'(cyc),             64'(e.c));
         end
      end
      if (bus.res_valid === 1'b1) begin
         if (res_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL res_unexpected: got data %0h idx %0d expected no result (cycle %0d)",
                     bus.res_data, bus.res_idx, cyc);
         end else begin
            r = res_q.pop_front();
            chk("res_data",  64'(bus.res_data), 64'(r.d));
            chk("res_id",    64'(bus.res_id),   64'(r.id));
            chk("res_idx",   64'(bus.res_idx),  64'(r.idx));
            chk("res_cycle", 64'(cyc),          64'(r.c));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int t);
      int n = 0;
      while (cyc < t && n < 200) begin
         step();
         n++;
      end
   endtask

   function automatic logic [4*DW-1:0] pack4(input logic [DW-1:0] w0, w1, w2, w3);
      return {w3, w2, w1, w0};
   endfunction

   task automatic push_words(input logic [DW-1:0] w0, w1, w2, w3, input logic m, input int t);
      eng_q.push_back('{w: w0, m: m, c: t + 1});
      eng_q.push_back('{w: w1, m: m, c: t + 2});
      eng_q.push_back('{w: w2, m: m, c: t + 3});
      eng_q.push_back('{w: w3, m: m, c: t + 4});
   endtask

   task automatic emit(input logic [OW-1:0] val, input logic id, input logic [1:0] idx);
      bus.eng_out_valid = 1'b1;
      bus.eng_out       = val;
      res_q.push_back('{id: id, idx: idx, d: val, c: cyc + 1});
      step();
      bus.eng_out_valid = 1'b0;
      bus.eng_out       = '0;
   endtask

   // offers a job on one requester, waits for its ready, returns the transfer cycle
   task automatic submit(input int id, input logic [DW-1:0] w0, w1, w2, w3,
                         input logic m, output int t);
      t = -1;
      if (id == 0) begin
         bus.req0_data = pack4(w0, w1, w2, w3); bus.req0_mode = m; bus.req0_valid = 1'b1;
      end else begin
         bus.req1_data = pack4(w0, w1, w2, w3); bus.req1_mode = m; bus.req1_valid = 1'b1;
      end
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if ((id == 0 && bus.req0_ready === 1'b1) || (id == 1 && bus.req1_ready === 1'b1)) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) begin
         checks++;
         failures++;
         $display("FAIL submit_timeout: got no ready for requester %0d expected ready within 60 cycles", id);
      end else begin
         chk("one_ready", 64'({bus.req1_ready, bus.req0_ready}), (id == 0) ? 64'd1 : 64'd2);
         push_words(w0, w1, w2, w3, m, t);
         step();
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.req0_data  = ~bus.req0_data; bus.req1_data = ~bus.req1_data;
      bus.req0_mode  = ~bus.req0_mode; bus.req1_mode = ~bus.req1_mode;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before 2ms");
      $fatal(1);
   end

   initial begin
      int t;
      int t2;
      int c0;
      int ec;
      logic g;

      bus.req0_valid = 1'b0; bus.req0_mode = 1'b0; bus.req0_data = '0;
      bus.req1_valid = 1'b0; bus.req1_mode = 1'b0; bus.req1_data = '0;
      bus.eng_out_valid = 1'b0; bus.eng_out = '0;

      // reset state
      repeat (3) step();
      @(negedge clk);
      chk("reset_outputs", 64'({bus.eng_in_valid, bus.eng_in, bus.eng_in_mode, bus.res_valid,
                                bus.res_id, bus.res_idx, bus.res_data, bus.err, bus.busy}), 64'd0);
      step();
      rst_n = 1'b1;
      step();

      // both requesters valid: grants alternate 0,1,0,1
      bus.req0_data = pack4(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3); bus.req0_mode = MODE_CMUL;
      bus.req1_data = pack4(16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3); bus.req1_mode = MODE_MINMAX;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      for (int j = 0; j < 4; j++) begin
         t = -1;
         for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin
               t = cyc;
               break;
            end
         end
         if (t < 0) begin
            checks++;
            failures++;
            $display("FAIL rr_timeout: got no ready expected a grant for job %0d", j);
            break;
         end
         g = (j % 2 == 1);
         chk("rr_grant", 64'({bus.req1_ready, bus.req0_ready}), g ? 64'd2 : 64'd1);
         if (g) push_words(16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3, MODE_MINMAX, t);
         else   push_words(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, MODE_CMUL, t);
         step();
         wait_to(t + 6);
         emit(36'h100 + 36'(j), g, 2'd0);
         emit(36'h200 + 36'(j), g, 2'd1);
         emit(36'h300 + 36'(j), g, 2'd2);
         if (j == 3) begin
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
         end
      end
      repeat (2) step();

      // single job on req0, exact latency and busy window
      submit(0, 16'h0102, 16'h0304, 16'h0506, 16'h0708, MODE_CMUL, t);
      bus.req1_valid = 1'b1;
      @(negedge clk);
      chk("no_ready_in_send", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
      bus.req1_valid = 1'b0;
      wait_to(t + 7);
      emit(36'h1_2345_6789, 1'b0, 2'd0);
      emit(36'hF_0000_0001, 1'b0, 2'd1);
      emit(36'h8_8888_8888, 1'b0, 2'd2);
      @(negedge clk);
      chk("busy_last_res", 64'(bus.busy), 64'd1);
      step();
      @(negedge clk);
      chk("busy_idle", 64'(bus.busy), 64'd0);
      step();

      // back-to-back: req1 granted in the cycle of the third result
      submit(0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, MODE_MINMAX, t);
      bus.req1_data = pack4(16'h5555, 16'h6666, 16'h7777, 16'h8888);
      bus.req1_mode = MODE_CMUL;
      bus.req1_valid = 1'b1;
      wait_to(t + 5);
      emit(36'hA_AAAA_0000, 1'b0, 2'd0);
      emit(36'hA_AAAA_0001, 1'b0, 2'd1);
      emit(36'hA_AAAA_0002, 1'b0, 2'd2);
      @(negedge clk);
      chk("b2b_ready", 64'({bus.res_valid, bus.req1_ready, bus.req0_ready}), 64'b110);
      t2 = cyc;
      push_words(16'h5555, 16'h6666, 16'h7777, 16'h8888, MODE_CMUL, t2);
      step();
      bus.req1_valid = 1'b0;
      wait_to(t2 + 5);
      emit(36'h5_0000_0000, 1'b1, 2'd0);
      emit(36'h5_0000_0001, 1'b1, 2'd1);
      emit(36'h5_0000_0002, 1'b1, 2'd2);
      repeat (2) step();

      // engine stalls after the first result
      submit(0, 16'hC000, 16'hC001, 16'hC002, 16'hC003, MODE_CMUL, t);
      wait_to(t + 5);
      c0 = cyc;
      chk("stall_err_before", 64'(bus.err), 64'd0);
      emit(36'h7_7777_7777, 1'b0, 2'd0);
      ec = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.err === 1'b1) begin
            ec = cyc;
            break;
         end
      end
      chk("stall_err_set", 64'(bus.err), 64'd1);
      chk("stall_err_window", 64'(ec >= c0 + 16 && ec <= c0 + 19), 64'd1);
      chk("stall_idle", 64'(bus.busy), 64'd0);
      step();
      submit(1, 16'hD000, 16'hD001, 16'hD002, 16'hD003, MODE_MINMAX, t);
      wait_to(t + 5);
      emit(36'h3_0000_0000, 1'b1, 2'd0);
      emit(36'h3_0000_0001, 1'b1, 2'd1);
      emit(36'h3_0000_0002, 1'b1, 2'd2);
      @(negedge clk);
      chk("err_sticky", 64'(bus.err), 64'd1);
      step();

      // reset during the second word of SEND
      submit(0, 16'hE000, 16'hE001, 16'hE002, 16'hE003, MODE_CMUL, t);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      eng_q.delete();
      @(negedge clk);
      chk("midjob_reset_outputs", 64'({bus.eng_in_valid, bus.eng_in, bus.eng_in_mode, bus.res_valid,
                                       bus.res_id, bus.res_idx, bus.res_data, bus.err, bus.busy}), 64'd0);
      bus.req0_data = pack4(16'hF000, 16'hF001, 16'hF002, 16'hF003); bus.req0_mode = MODE_MINMAX;
      bus.req1_data = pack4(16'h9000, 16'h9001, 16'h9002, 16'h9003); bus.req1_mode = MODE_CMUL;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      #1;
      chk("first_grant_after_reset", 64'({bus.req1_ready, bus.req0_ready}), 64'd1);
      t = cyc;
      push_words(16'hF000, 16'hF001, 16'hF002, 16'hF003, MODE_MINMAX, t);
      step();
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

      // spurious engine strobe during SEND
      wait_to(t + 2);
      bus.eng_out_valid = 1'b1;
      bus.eng_out       = 36'h0_0000_0BAD;
      step();
      bus.eng_out_valid = 1'b0;
      bus.eng_out       = '0;
      @(negedge clk);
      chk("spurious_err", 64'(bus.err), 64'd1);
      wait_to(t + 6);
      emit(36'h6_0000_0000, 1'b0, 2'd0);
      emit(36'h6_0000_0001, 1'b0, 2'd1);
      emit(36'h6_0000_0002, 1'b0, 2'd2);

      repeat (5) step();
      chk("eng_q_drained", 64'(eng_q.size()), 64'd0);
      chk("res_q_drained", 64'(res_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
